// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, control-bus bit positions and hazard FSM encoding
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  // Bit positions inside the 3-bit mem control field carried down the pipe
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } hz_state_t;

  // Instructions whose rt field is a source operand
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and async active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use and BEQ hazard sequencing for the 5-stage pipeline
module hazard_ctrl_unit
  import cpu_pkg::*;
#(
  parameter bit BR_STALL = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       if_id_opcode,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_branch,
  input  logic             ex_mem_zero,
  output logic             pc_write,
  output logic             pc_src,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             ctrl_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t state;
  logic      wait_cnt;
  logic      load_use;
  logic      taken;
  logic      is_beq;
  logic      stall_en;
  logic      flush_en;

  // Hazard detection terms; register 0 is never a real dependency
  always_comb begin
    load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == if_id_rs) || (uses_rt(if_id_opcode) && (id_ex_rt == if_id_rt)));
    taken    = ex_mem_branch && ex_mem_zero;
    is_beq   = (if_id_opcode == OP_BEQ);
  end

  // Zero-latency pipeline controls: reset, then taken flush, then branch wait, then load-use
  always_comb begin
    pc_write     = 1'b1;
    pc_src       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    ctrl_bubble  = 1'b0;
    if (!rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      ctrl_bubble  = 1'b1;
    end else if (!BR_STALL && taken) begin
      pc_src       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (state == ST_BR_WAIT) begin
      if_id_flush = 1'b1;
      if (wait_cnt) begin
        pc_write = 1'b0;
      end else begin
        pc_src = taken;
      end
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctrl_bubble = 1'b1;
    end else if (BR_STALL && is_beq) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Branch-freeze sequencer: BEQ in ID -> wait while it is in EX -> resolve in MEM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      wait_cnt <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (BR_STALL && is_beq && !load_use) begin
            state    <= ST_BR_WAIT;
            wait_cnt <= 1'b1;
          end
        end
        ST_BR_WAIT: begin
          if (wait_cnt) begin
            wait_cnt <= 1'b0;
          end else begin
            state <= ST_RUN;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= 1'b0;
        end
      endcase
    end
  end

  // Performance counter enables
  always_comb begin
    stall_en = !pc_write;
    if (BR_STALL) begin
      flush_en = (state == ST_BR_WAIT) && !wait_cnt && taken;
    end else begin
      flush_en = taken;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_en),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush_en),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit in both branch modes
module tb_hazard_ctrl_unit;
  import cpu_pkg::*;

  // ctrl vector order: {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, ctrl_bubble}
  localparam logic [6:0] C_DEF = 7'b1010000;
  localparam logic [6:0] C_LU  = 7'b0000001;
  localparam logic [6:0] C_RST = 7'b0001111;
  localparam logic [6:0] C_TK  = 7'b1111110;
  localparam logic [6:0] C_BRS = 7'b0011000;
  localparam logic [6:0] C_BRT = 7'b1111000;
  localparam logic [6:0] C_BRN = 7'b1011000;

  typedef struct {
    logic       r;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       z;
    int         sel;
    logic [6:0] c;
    logic [15:0] st;
    logic [15:0] fl;
  } step_t;

  typedef struct {
    int          sel;
    logic [6:0]  c;
    logic [15:0] st;
    logic [15:0] fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  if_id_opcode = OP_RTYPE;
  logic [4:0]  if_id_rs = '0;
  logic [4:0]  if_id_rt = '0;
  logic        id_ex_memread = 1'b0;
  logic [4:0]  id_ex_rt = '0;
  logic        ex_mem_branch = 1'b0;
  logic        ex_mem_zero = 1'b0;

  logic [6:0]  ctrl [3];
  logic [15:0] scnt [3];
  logic [15:0] fcnt [3];

  logic pw0, ps0, iw0, f10, f20, f30, b0;
  logic pw1, ps1, iw1, f11, f21, f31, b1;
  logic pw2, ps2, iw2, f12, f22, f32, b2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.BR_STALL(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .ex_mem_branch(ex_mem_branch),
    .ex_mem_zero(ex_mem_zero), .pc_write(pw0), .pc_src(ps0), .if_id_write(iw0),
    .if_id_flush(f10), .id_ex_flush(f20), .ex_mem_flush(f30), .ctrl_bubble(b0),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  hazard_ctrl_unit #(.BR_STALL(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .ex_mem_branch(ex_mem_branch),
    .ex_mem_zero(ex_mem_zero), .pc_write(pw1), .pc_src(ps1), .if_id_write(iw1),
    .if_id_flush(f11), .id_ex_flush(f21), .ex_mem_flush(f31), .ctrl_bubble(b1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_ctrl_unit #(.BR_STALL(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .ex_mem_branch(ex_mem_branch),
    .ex_mem_zero(ex_mem_zero), .pc_write(pw2), .pc_src(ps2), .if_id_write(iw2),
    .if_id_flush(f12), .id_ex_flush(f22), .ex_mem_flush(f32), .ctrl_bubble(b2),
    .stall_cnt(sc2), .flush_cnt(fc2)
  );

  assign ctrl[0] = {pw0, ps0, iw0, f10, f20, f30, b0};
  assign ctrl[1] = {pw1, ps1, iw1, f11, f21, f31, b1};
  assign ctrl[2] = {pw2, ps2, iw2, f12, f22, f32, b2};
  assign scnt[0] = sc0;
  assign scnt[1] = sc1;
  assign scnt[2] = {12'd0, sc2};
  assign fcnt[0] = fc0;
  assign fcnt[1] = fc1;
  assign fcnt[2] = {12'd0, fc2};

  function automatic step_t mk(input int sel, input logic [5:0] op, input int rs, input int rt,
                               input int mr, input int ert, input int br, input int z,
                               input logic [6:0] c, input int st, input int fl, input int r = 1);
    step_t s;
    s.r   = (r != 0);
    s.op  = op;
    s.rs  = 5'(rs);
    s.rt  = 5'(rt);
    s.mr  = (mr != 0);
    s.ert = 5'(ert);
    s.br  = (br != 0);
    s.z   = (z != 0);
    s.sel = sel;
    s.c   = c;
    s.st  = 16'(st);
    s.fl  = 16'(fl);
    return s;
  endfunction

  // Drive one cycle of stimulus just after the edge, queue its expectation, move to the sampling point
  task automatic drive_step(input step_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = s.r;
    if_id_opcode  = s.op;
    if_id_rs      = s.rs;
    if_id_rt      = s.rt;
    id_ex_memread = s.mr;
    id_ex_rt      = s.ert;
    ex_mem_branch = s.br;
    ex_mem_zero   = s.z;
    e.sel = s.sel;
    e.c   = s.c;
    e.st  = s.st;
    e.fl  = s.fl;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_id_opcode = OP_RTYPE; if_id_rs = '0; if_id_rt = '0;
    id_ex_memread = 1'b0; id_ex_rt = '0; ex_mem_branch = 1'b0; ex_mem_zero = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    step_t t [$];
    exp_t  e;
    for (int k = 0; k < 3; k++) t.push_back(mk(k, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0));
    for (int k = 0; k < 3; k++) t.push_back(mk(k, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0));
    foreach (t[i]) begin
      drive_step(t[i]);
      e = sb.pop_front();
      n_cmp++; if (ctrl[e.sel] !== e.c) begin n_bad++; $display("FAIL reset_ctrl[%0d] dut%0d got %b want %b", i, e.sel, ctrl[e.sel], e.c); end
      n_cmp++; if (scnt[e.sel] !== e.st) begin n_bad++; $display("FAIL reset_stall[%0d] dut%0d got %0d want %0d", i, e.sel, scnt[e.sel], e.st); end
      n_cmp++; if (fcnt[e.sel] !== e.fl) begin n_bad++; $display("FAIL reset_flush[%0d] dut%0d got %0d want %0d", i, e.sel, fcnt[e.sel], e.fl); end
    end
  endtask

  task automatic test_load_use_rs();
    step_t t [$];
    exp_t  e;
    do_reset();
    t.push_back(mk(0, OP_RTYPE, 5, 0, 1, 5, 0, 0, C_LU,  0, 0));
    t.push_back(mk(0, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 1, 0));
    t.push_back(mk(0, OP_RTYPE, 0, 0, 1, 0, 0, 0, C_DEF, 1, 0));
    t.push_back(mk(0, OP_RTYPE, 5, 0, 1, 5, 0, 0, C_LU,  1, 0));
    t.push_back(mk(0, OP_RTYPE, 5, 0, 1, 5, 0, 0, C_LU,  2, 0));
    t.push_back(mk(0, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 3, 0));
    foreach (t[i]) begin
      drive_step(t[i]);
      e = sb.pop_front();
      n_cmp++; if (ctrl[e.sel] !== e.c) begin n_bad++; $display("FAIL lu_rs_ctrl[%0d] got %b want %b", i, ctrl[e.sel], e.c); end
      n_cmp++; if (scnt[e.sel] !== e.st) begin n_bad++; $display("FAIL lu_rs_stall[%0d] got %0d want %0d", i, scnt[e.sel], e.st); end
      n_cmp++; if (fcnt[e.sel] !== e.fl) begin n_bad++; $display("FAIL lu_rs_flush[%0d] got %0d want %0d", i, fcnt[e.sel], e.fl); end
    end
  endtask

  task automatic test_load_use_rt();
    step_t t [$];
    exp_t  e;
    t.push_back(mk(0, OP_LW,    3, 7, 1, 7, 0, 0, C_DEF, 3, 0));
    t.push_back(mk(0, OP_SW,    3, 7, 1, 7, 0, 0, C_LU,  3, 0));
    t.push_back(mk(0, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 4, 0));
    t.push_back(mk(0, OP_BEQ,   3, 7, 1, 7, 0, 0, C_LU,  4, 0));
    t.push_back(mk(0, OP_NOP,   3, 7, 1, 7, 0, 0, C_DEF, 5, 0));
    t.push_back(mk(0, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 5, 0));
    foreach (t[i]) begin
      drive_step(t[i]);
      e = sb.pop_front();
      n_cmp++; if (ctrl[e.sel] !== e.c) begin n_bad++; $display("FAIL lu_rt_ctrl[%0d] got %b want %b", i, ctrl[e.sel], e.c); end
      n_cmp++; if (scnt[e.sel] !== e.st) begin n_bad++; $display("FAIL lu_rt_stall[%0d] got %0d want %0d", i, scnt[e.sel], e.st); end
    end
  endtask

  task automatic test_taken_flush();
    step_t t [$];
    exp_t  e;
    do_reset();
    t.push_back(mk(0, OP_RTYPE, 5, 0, 1, 5, 1, 1, C_TK,  0, 0));
    t.push_back(mk(0, OP_RTYPE, 0, 0, 0, 0, 1, 0, C_DEF, 0, 1));
    t.push_back(mk(0, OP_RTYPE, 5, 0, 1, 5, 1, 0, C_LU,  0, 1));
    t.push_back(mk(0, OP_RTYPE, 0, 0, 0, 0, 1, 1, C_TK,  1, 1));
    t.push_back(mk(0, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 1, 2));
    foreach (t[i]) begin
      drive_step(t[i]);
      e = sb.pop_front();
      n_cmp++; if (ctrl[e.sel] !== e.c) begin n_bad++; $display("FAIL taken_ctrl[%0d] got %b want %b", i, ctrl[e.sel], e.c); end
      n_cmp++; if (scnt[e.sel] !== e.st) begin n_bad++; $display("FAIL taken_stall[%0d] got %0d want %0d", i, scnt[e.sel], e.st); end
      n_cmp++; if (fcnt[e.sel] !== e.fl) begin n_bad++; $display("FAIL taken_flush[%0d] got %0d want %0d", i, fcnt[e.sel], e.fl); end
    end
  endtask

  task automatic test_br_stall();
    step_t t [$];
    exp_t  e;
    do_reset();
    t.push_back(mk(1, OP_BEQ,   0, 0, 0, 0, 0, 0, C_BRS, 0, 0));
    t.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 0, 0, C_BRS, 1, 0));
    t.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 1, 1, C_BRT, 2, 0));
    t.push_back(mk(1, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 2, 1));
    t.push_back(mk(1, OP_BEQ,   0, 4, 1, 4, 0, 0, C_LU,  2, 1));
    t.push_back(mk(1, OP_BEQ,   0, 4, 0, 0, 0, 0, C_BRS, 3, 1));
    t.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 0, 0, C_BRS, 4, 1));
    t.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 1, 0, C_BRN, 5, 1));
    t.push_back(mk(1, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 5, 1));
    foreach (t[i]) begin
      drive_step(t[i]);
      e = sb.pop_front();
      n_cmp++; if (ctrl[e.sel] !== e.c) begin n_bad++; $display("FAIL brst_ctrl[%0d] got %b want %b", i, ctrl[e.sel], e.c); end
      n_cmp++; if (scnt[e.sel] !== e.st) begin n_bad++; $display("FAIL brst_stall[%0d] got %0d want %0d", i, scnt[e.sel], e.st); end
      n_cmp++; if (fcnt[e.sel] !== e.fl) begin n_bad++; $display("FAIL brst_flush[%0d] got %0d want %0d", i, fcnt[e.sel], e.fl); end
    end
  endtask

  task automatic test_reset_mid_wait();
    step_t t [$];
    exp_t  e;
    do_reset();
    t.push_back(mk(1, OP_RTYPE, 5, 0, 1, 5, 0, 0, C_LU,  0, 0));
    t.push_back(mk(1, OP_BEQ,   0, 0, 0, 0, 0, 0, C_BRS, 1, 0));
    t.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0));
    t.push_back(mk(1, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0));
    t.push_back(mk(1, OP_RTYPE, 0, 0, 0, 0, 1, 1, C_DEF, 0, 0));
    t.push_back(mk(1, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0));
    foreach (t[i]) begin
      drive_step(t[i]);
      e = sb.pop_front();
      n_cmp++; if (ctrl[e.sel] !== e.c) begin n_bad++; $display("FAIL midrst_ctrl[%0d] got %b want %b", i, ctrl[e.sel], e.c); end
      n_cmp++; if (scnt[e.sel] !== e.st) begin n_bad++; $display("FAIL midrst_stall[%0d] got %0d want %0d", i, scnt[e.sel], e.st); end
      n_cmp++; if (fcnt[e.sel] !== e.fl) begin n_bad++; $display("FAIL midrst_flush[%0d] got %0d want %0d", i, fcnt[e.sel], e.fl); end
    end
  endtask

  task automatic test_saturation();
    step_t t [$];
    exp_t  e;
    do_reset();
    for (int k = 0; k < 20; k++) t.push_back(mk(2, OP_RTYPE, 5, 0, 1, 5, 0, 0, C_LU, (k < 15) ? k : 15, 0));
    t.push_back(mk(2, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 15, 0));
    t.push_back(mk(2, OP_RTYPE, 0, 0, 0, 0, 0, 0, C_DEF, 15, 0));
    foreach (t[i]) begin
      drive_step(t[i]);
      e = sb.pop_front();
      n_cmp++; if (ctrl[e.sel] !== e.c) begin n_bad++; $display("FAIL sat_ctrl[%0d] got %b want %b", i, ctrl[e.sel], e.c); end
      n_cmp++; if (scnt[e.sel] !== e.st) begin n_bad++; $display("FAIL sat_stall[%0d] got %0d want %0d", i, scnt[e.sel], e.st); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use_rs();
    test_load_use_rt();
    test_taken_flush();
    test_br_stall();
    test_reset_mid_wait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It sequences the IF, ID, EX and MEM stages around the decode control block. It detects load-use hazards and freezes fetch/decode while injecting a control bubble into ID/EX. It also handles BEQ, either by flushing on a taken branch (predict-not-taken) or by freezing fetch until the branch resolves in MEM, with saturating counters for stall and flush cycles.

Parameters:
BR_STALL, 0, branch policy: 0 = predict-not-taken with flush on taken; 1 = freeze fetch until the BEQ resolves in MEM.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
if_id_opcode  in  6  opcode in IF/ID
if_id_rs  in  5  rs field in IF/ID
if_id_rt  in  5  rt field in IF/ID
id_ex_memread  in  1  ID/EX mem[1] (load in EX)
id_ex_rt  in  5  destination rt of the instruction in EX
ex_mem_branch  in  1  EX/MEM mem[2] (BEQ in MEM)
ex_mem_zero  in  1  ALU zero flag in EX/MEM
pc_write  out  1  PC load enable
pc_src  out  1  1 = load branch target into PC
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  clear IF/ID to NOP on next edge
id_ex_flush  out  1  clear ID/EX on next edge
ex_mem_flush  out  1  clear EX/MEM on next edge
ctrl_bubble  out  1  force wb/mem/ex into ID/EX to zero
stall_cnt  out  CNT_W  cycles with pc_write=0 (saturating)
flush_cnt  out  CNT_W  taken-branch flush events (saturating)

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0.
  - While rst=0: pc_write=0, if_id_write=0, pc_src=0, ctrl_bubble=1, all three flushes=1.
- FSM states: RUN, BR_WAIT. A 1-bit wait counter is used only in BR_WAIT.
- Control outputs are combinational from state and inputs, with zero latency. Counters and state are registered.
- uses_rt = 1 when if_id_opcode is 000000 (R-type), 101011 (SW) or 000100 (BEQ).
- load_use = id_ex_memread & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (uses_rt & (id_ex_rt == if_id_rt))).
- taken = ex_mem_branch & ex_mem_zero.
- Defaults: pc_write=1, if_id_write=1, pc_src=0, all flushes=0, ctrl_bubble=0.
- Priority: taken > BR_WAIT sequencing > load_use.
- taken, BR_STALL=0:
  - pc_src=1, pc_write=1.
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - load_use in the same cycle is ignored (the loaded instruction is squashed).
  - flush_cnt increments.
- load_use in RUN, not taken: pc_write=0, if_id_write=0, ctrl_bubble=1 for exactly one cycle. Normal advance handles the rest; no state change.
- BR_STALL=1, RUN, if_id_opcode=000100, no load_use:
  - pc_write=0, if_id_flush=1 this cycle.
  - Next state BR_WAIT, counter=1.
- BR_STALL=1, BEQ in ID with load_use: the load-use stall happens first. BR_WAIT is entered on the following cycle.
- BR_WAIT, counter=1 (BEQ in EX): pc_write=0, if_id_flush=1; counter becomes 0.
- BR_WAIT, counter=0 (BEQ in MEM):
  - pc_write=1, pc_src=taken, if_id_flush=1.
  - Return to RUN.
  - flush_cnt increments if taken.
  - No EX/MEM flush in this mode.
- stall_cnt increments every out-of-reset cycle with pc_write=0.
- Both counters saturate at all-ones and do not wrap.
- Reset asserted mid-BR_WAIT aborts the sequence. After release the FSM is in RUN with no pending stall.
- A register index of 0 never triggers load_use.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_NOP=100000
  - control-bus bit positions: mem[2]=branch, mem[1]=memread, mem[0]=memwrite
  - FSM state encoding
- Sub-module sat_counter (width-parameterised, enable, async active-low clear), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release.
  - During reset: pc_write=0, all flushes=1, ctrl_bubble=1.
  - First cycle after release: defaults, both counters 0.
- Load-use on rs: id_ex_memread=1, id_ex_rt=5, if_id_rs=5, opcode R-type.
  - One cycle of pc_write=0, if_id_write=0, ctrl_bubble=1; stall_cnt=1.
  - Repeat with rt=0: no stall.
- Load-use on rt: id_ex_rt=7, if_id_rt=7, opcode LW (rt not used) -> no stall. Same with opcode SW -> stall.
- BR_STALL=0, taken BEQ: ex_mem_branch=1, ex_mem_zero=1, load_use also true.
  - pc_src=1, pc_write=1, all three flushes=1, ctrl_bubble=0; flush_cnt=1.
  - With zero=0: defaults only.
- BR_STALL=1: BEQ enters ID at cycle t.
  - pc_write=0 at t and t+1.
  - At t+2 with branch=1, zero=1: pc_write=1, pc_src=1.
  - if_id_flush=1 for cycles t..t+2; stall_cnt=2, flush_cnt=1.
  - Assert rst=0 at t+1: returns to RUN, counters 0.
- Saturation: with CNT_W=4, force 20 stall cycles -> stall_cnt holds at 15.
